// File: rtl/frog_game_sequencer_pkg.sv
// Shared constants for the frog game flow controller: state encodings and default frame counts.
package frog_game_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT   = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_HIT       = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_e;

  localparam int unsigned LivesInitDef      = 3;
  localparam int unsigned MaxLevelDef       = 9;
  localparam int unsigned HitFramesDef      = 60;
  localparam int unsigned LevelupFramesDef  = 90;
  localparam int unsigned GameoverFramesDef = 180;

endpackage

// File: rtl/frog_game_sequencer_bcd_score_counter.sv
// Two-digit BCD score counter with clear, increment and saturation at 99.
module bcd_score_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       inc_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  logic [3:0] tens_d, tens_q;
  logic [3:0] units_d, units_q;
  logic       at_max;

  assign at_max = (tens_q == 4'd9) && (units_q == 4'd9);

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clear_i) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (inc_i && !at_max) begin
      if (units_q == 4'd9) begin
        units_d = 4'd0;
        tens_d  = tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_o  = tens_q;
  assign units_o = units_q;

endmodule

// File: rtl/frog_game_sequencer.sv
// Game-flow controller: sequences attract/play/hit/level-up/game-over and owns lives, level
// and score. Every output is a register.
module frog_game_sequencer
  import frog_game_sequencer_pkg::*;
#(
  parameter int unsigned LIVES_INIT      = LivesInitDef,
  parameter int unsigned MAX_LEVEL       = MaxLevelDef,
  parameter int unsigned HIT_FRAMES      = HitFramesDef,
  parameter int unsigned LEVELUP_FRAMES  = LevelupFramesDef,
  parameter int unsigned GAMEOVER_FRAMES = GameoverFramesDef
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       frame_tick,
  input  logic       any_key,
  input  logic       collision,
  input  logic       goal_reached,
  output logic [2:0] game_state,
  output logic       cars_enable,
  output logic       player_reset,
  output logic       player_flash,
  output logic [3:0] level,
  output logic [1:0] lives,
  output logic [3:0] score_tens,
  output logic [3:0] score_units
);

  localparam logic [1:0] LivesInit   = 2'(LIVES_INIT);
  localparam logic [3:0] MaxLevel    = 4'(MAX_LEVEL);
  localparam logic [7:0] HitLast     = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] LevelupLast = 8'(LEVELUP_FRAMES - 1);
  localparam logic [7:0] GameoverMin = 8'(GAMEOVER_FRAMES);

  game_state_e state_d, state_q;
  logic [7:0]  frame_cnt_d, frame_cnt_q;
  logic [1:0]  lives_d, lives_q;
  logic [3:0]  level_d, level_q;
  logic        player_reset_d, player_reset_q;
  logic        player_flash_d, player_flash_q;
  logic        cars_enable_d, cars_enable_q;
  logic        any_key_d_q;
  logic        key_armed_q;
  logic        key_edge;
  logic        score_inc;
  logic        score_clr;

  // A key already down when reset releases must not count: edges are armed only once a
  // released key has been sampled.
  assign key_edge = any_key && !any_key_d_q && key_armed_q;

  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    level_d        = level_q;
    player_reset_d = 1'b0;
    score_inc      = 1'b0;
    score_clr      = 1'b0;

    case (state_q)
      ST_ATTRACT: begin
        if (key_edge) begin
          lives_d        = LivesInit;
          level_d        = 4'd1;
          score_clr      = 1'b1;
          player_reset_d = 1'b1;
          state_d        = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (collision) begin
          state_d = ST_HIT;
        end else if (goal_reached) begin
          score_inc      = 1'b1;
          player_reset_d = 1'b1;
          state_d        = ST_LEVEL_UP;
          if (level_q < MaxLevel) level_d = level_q + 4'd1;
        end
      end
      ST_HIT: begin
        if (frame_tick && (frame_cnt_q == HitLast)) begin
          if (lives_q == 2'd1) begin
            lives_d = 2'd0;
            state_d = ST_GAME_OVER;
          end else begin
            lives_d        = lives_q - 2'd1;
            player_reset_d = 1'b1;
            state_d        = ST_PLAYING;
          end
        end
      end
      ST_LEVEL_UP: begin
        if (frame_tick && (frame_cnt_q == LevelupLast)) state_d = ST_PLAYING;
      end
      ST_GAME_OVER: begin
        if (key_edge && (frame_cnt_q >= GameoverMin)) state_d = ST_ATTRACT;
      end
      default: state_d = ST_ATTRACT;
    endcase

    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (frame_tick && (frame_cnt_q != 8'hff)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    // Derived from next-state values so these outputs line up with game_state.
    cars_enable_d  = (state_d == ST_PLAYING);
    player_flash_d = (state_d == ST_HIT) && frame_cnt_d[3];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_ATTRACT;
      frame_cnt_q    <= 8'd0;
      lives_q        <= 2'd0;
      level_q        <= 4'd1;
      player_reset_q <= 1'b0;
      player_flash_q <= 1'b0;
      cars_enable_q  <= 1'b0;
      any_key_d_q    <= 1'b0;
      key_armed_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      lives_q        <= lives_d;
      level_q        <= level_d;
      player_reset_q <= player_reset_d;
      player_flash_q <= player_flash_d;
      cars_enable_q  <= cars_enable_d;
      any_key_d_q    <= any_key;
      key_armed_q    <= key_armed_q | ~any_key;
    end
  end

  bcd_score_counter u_score (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clear_i (score_clr),
    .inc_i   (score_inc),
    .tens_o  (score_tens),
    .units_o (score_units)
  );

  assign game_state   = state_q;
  assign cars_enable  = cars_enable_q;
  assign player_reset = player_reset_q;
  assign player_flash = player_flash_q;
  assign level        = level_q;
  assign lives        = lives_q;

endmodule
